// File: rtl/cpu_mult_cell_seq.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mult_cell_seq
// Description : Sequencer for a 3-partial-product 16x16 multiplier cell.
//               It runs two passes through the cell for every request and
//               assembles the full 64-bit product of two 32-bit operands.
//               Pass 1 forms a_lo*b_lo + (a_lo*b_hi + a_hi*b_lo)<<16.
//               Pass 2 feeds {a_hi} x {b_hi}, so cell output p1 is a_hi*b_hi.
//               That term is added at bit 32.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   clock, rising edge
//   reset        in   1   synchronous reset, active-high
//   req_valid    in   1   request present
//   req_ready    out  1   ready to accept (IDLE only)
//   req_a/req_b  in   32  operands
//   req_signed   in   1   signed operands (MUL_SIGNED_EN builds only)
//   rsp_valid    out  1   result valid, held until accepted
//   rsp_ready    in   1   consumer accepts result
//   rsp_lo/hi    out  32  product [31:0] / [63:32]
//   mul_src1/2   out  32  cell operands
//   mul_en       out  1   cell capture enable
//   mul_p1/2/3   in   32  cell partial products
// Configuration
//   MUL_SIGNED_EN : when defined, signed requests get a high-word correction
//                   applied in the FIN stage.
// ============================================================================
module cpu_mult_cell_seq #(
    parameter logic [63:0] RST_RESULT = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_signed,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    output logic        mul_en,
    input  logic [31:0] mul_p1,
    input  logic [31:0] mul_p2,
    input  logic [31:0] mul_p3
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LO   = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_RSP  = 3'd4;

    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [63:0] prod_d;
    logic [31:0] hi_d;
    logic [31:0] rsp_lo_q;
    logic [31:0] rsp_hi_q;
    logic        rsp_valid_q;
    logic [32:0] mid_sum;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = S_LO;
            S_LO:    state_d = S_HI;
            S_HI:    state_d = S_FIN;
            S_FIN:   state_d = S_RSP;
            S_RSP:   if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        req_ready = 1'b0;
        mul_en    = 1'b0;
        mul_src1  = 32'h0;
        mul_src2  = 32'h0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_LO: begin
                mul_en   = 1'b1;
                mul_src1 = a_q;
                mul_src2 = b_q;
            end
            S_HI: begin
                // High halves placed in the low lanes so p1 = a_hi*b_hi and
                // the cross products p2/p3 come out zero.
                mul_en   = 1'b1;
                mul_src1 = {16'h0, a_q[31:16]};
                mul_src2 = {16'h0, b_q[31:16]};
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    // Cross terms summed at 33 bits so their carry survives the shift.
    assign mid_sum = {1'b0, mul_p2} + {1'b0, mul_p3};
    assign acc_d   = {32'h0, mul_p1} + {15'h0, mid_sum, 16'h0};
    assign prod_d  = acc_q + {mul_p1, 32'h0};

`ifdef MUL_SIGNED_EN
    logic signed_q;

    // Two's-complement fix-up of the unsigned product's upper word.
    assign hi_d = prod_d[63:32]
                - (signed_q && a_q[31] ? b_q : 32'h0)
                - (signed_q && b_q[31] ? a_q : 32'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            signed_q <= 1'b0;
        end else if (state_q == S_IDLE && req_valid) begin
            signed_q <= req_signed;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = req_signed;
    assign hi_d          = prod_d[63:32];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            acc_q       <= 64'h0;
            rsp_lo_q    <= RST_RESULT[31:0];
            rsp_hi_q    <= RST_RESULT[63:32];
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        a_q <= req_a;
                        b_q <= req_b;
                    end
                end
                S_HI: acc_q <= acc_d;
                S_FIN: begin
                    rsp_lo_q    <= prod_d[31:0];
                    rsp_hi_q    <= hi_d;
                    rsp_valid_q <= 1'b1;
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_lo    = rsp_lo_q;
    assign rsp_hi    = rsp_hi_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mult_cell_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mult_cell_seq
// Description : Self-checking bench for cpu_mult_cell_seq with a behavioural
//               model of the 3-partial-product multiplier cell.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mult_cell_seq;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_signed;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic        mul_en;
    logic [31:0] mul_p1;
    logic [31:0] mul_p2;
    logic [31:0] mul_p3;

    int checks;
    int failures;

    cpu_mult_cell_seq #(.RST_RESULT(64'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_lo     (rsp_lo),
        .rsp_hi     (rsp_hi),
        .mul_src1   (mul_src1),
        .mul_src2   (mul_src2),
        .mul_en     (mul_en),
        .mul_p1     (mul_p1),
        .mul_p2     (mul_p2),
        .mul_p3     (mul_p3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier cell model: one register stage gated by enable.
    always @(posedge clk) begin
        if (reset) begin
            mul_p1 <= 32'h0;
            mul_p2 <= 32'h0;
            mul_p3 <= 32'h0;
        end else if (mul_en) begin
            mul_p1 <= 32'(mul_src1[15:0]) * 32'(mul_src2[15:0]);
            mul_p2 <= 32'(mul_src1[15:0]) * 32'(mul_src2[31:16]);
            mul_p3 <= 32'(mul_src1[31:16]) * 32'(mul_src2[15:0]);
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request, track latency/mul_en, check result, accept it.
    task automatic run_vec(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp);
        int en_cnt;
        logic [3:0] vld;
        logic [31:0] src1_lo;
        logic [31:0] src1_hi;
        en_cnt = 0;
        vld    = 4'h0;
        @(negedge clk);
        check($sformatf("v%0d_req_ready", idx), {63'h0, req_ready}, 64'h1);
        req_valid  = 1'b1;
        req_a      = a;
        req_b      = b;
        req_signed = sgn;
        @(posedge clk);
        #1;
        // Operands must be latched; scramble the bus after acceptance.
        req_valid = 1'b0;
        req_a     = 32'hA5A5_5A5A;
        req_b     = 32'h3C3C_C3C3;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (mul_en) en_cnt++;
            vld[k] = rsp_valid;
            if (k == 0) src1_lo = mul_src1;
            if (k == 1) src1_hi = mul_src1;
        end
        check($sformatf("v%0d_latency", idx), {60'h0, vld}, 64'h8);
        check($sformatf("v%0d_mul_en_cycles", idx), 64'(en_cnt), 64'd2);
        check($sformatf("v%0d_src1_passes", idx), {src1_lo, src1_hi},
              {a, 16'h0, a[31:16]});
        check($sformatf("v%0d_product", idx), {rsp_hi, rsp_lo}, exp);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check($sformatf("v%0d_after_accept", idx), {62'h0, rsp_valid, req_ready}, 64'h1);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_a      = 32'h0;
        req_b      = 32'h0;
        req_signed = 1'b0;
        rsp_ready  = 1'b0;

        vecs[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[1]  = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000};
        vecs[2]  = '{32'h0000_FFFF, 32'h0001_0001, 1'b0, 64'h0000_0000_FFFF_FFFF};
        vecs[3]  = '{32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0000_0000_0000_0000};
        vecs[4]  = '{32'h0000_0001, 32'hDEAD_BEEF, 1'b0, 64'h0000_0000_DEAD_BEEF};
        vecs[5]  = '{32'h0000_0002, 32'h8000_0000, 1'b0, 64'h0000_0001_0000_0000};
        vecs[6]  = '{32'h0001_0000, 32'hFFFF_FFFF, 1'b0, 64'h0000_FFFF_FFFF_0000};
        vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE};
`ifdef MUL_SIGNED_EN
        vecs[8]  = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
`else
        vecs[8]  = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'h0000_0001_FFFF_FFFE};
`endif
        vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        vecs[10] = '{32'h0003_0000, 32'h0005_0000, 1'b0, 64'h0000_000F_0000_0000};
        vecs[11] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 64'h0000_0000_FFFE_0001};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset_result", {rsp_hi, rsp_lo}, 64'h0);
        check("reset_ctrl", {61'h0, rsp_valid, req_ready, mul_en}, 64'h2);
        check("reset_src", {mul_src1, mul_src2}, 64'h0);

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp);
        end

        // Back-pressure: response held 10 cycles, busy requests ignored.
        begin
            logic stable_ok;
            stable_ok = 1'b1;
            @(negedge clk);
            req_valid = 1'b1;
            req_a     = 32'h0000_1234;
            req_b     = 32'h0000_0010;
            @(posedge clk);
            #1;
            req_a = 32'hFFFF_FFFF;
            req_b = 32'hFFFF_FFFF;
            repeat (3) @(posedge clk);
            #1;
            for (int k = 0; k < 10; k++) begin
                if (!rsp_valid || req_ready || {rsp_hi, rsp_lo} !== 64'h0001_2340)
                    stable_ok = 1'b0;
                @(posedge clk);
                #1;
            end
            req_valid = 1'b0;
            check("stall_stable", {63'h0, stable_ok}, 64'h1);
            check("stall_result", {rsp_hi, rsp_lo}, 64'h0001_2340);
            @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            check("stall_idle", {62'h0, rsp_valid, req_ready}, 64'h1);
        end

        // Reset while in HI: in-flight op discarded, no response.
        begin
            logic saw_rsp;
            saw_rsp = 1'b0;
            @(negedge clk);
            req_valid = 1'b1;
            req_a     = 32'h0000_0007;
            req_b     = 32'h0000_0009;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            @(posedge clk);
            #1;
            check("pre_reset_in_hi", {mul_en, mul_src1}, {1'b1, 32'h0});
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            check("midreset_ctrl", {61'h0, rsp_valid, req_ready, mul_en}, 64'h2);
            check("midreset_result", {rsp_hi, rsp_lo}, 64'h0);
            for (int k = 0; k < 6; k++) begin
                @(posedge clk);
                #1;
                if (rsp_valid) saw_rsp = 1'b1;
            end
            check("midreset_no_rsp", {63'h0, saw_rsp}, 64'h0);
        end

        // Normal operation resumes after the aborted request.
        run_vec(12, 32'h0000_0007, 32'h0000_0009, 1'b0, 64'd63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
